// File: rtl/keyboard_common.sv
// rtl/keyboard_common.sv - shared keyboard types, set-2 scancodes and helpers
package keyboard_common;

  typedef logic [7:0] ascii_t;

  typedef struct packed {
    logic       is_break;
    logic       is_extended;
    logic [7:0] keycode;
  } kbd_event_t;

  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CTRL     = 8'h14;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;

  function automatic logic is_letter(ascii_t c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

endpackage

// File: rtl/kbd_keymap_rom.sv
// rtl/kbd_keymap_rom.sv - set-2 keycode to {unshifted, shifted} ASCII table
module kbd_keymap_rom
  import keyboard_common::*;
(
  input  logic [7:0] keycode_i,
  output ascii_t     unshifted_o,
  output ascii_t     shifted_o
);

  logic [15:0] pair;

  always_comb begin
    pair = 16'h0000;
    case (keycode_i)
      8'h1C: pair = {"a", "A"};
      8'h32: pair = {"b", "B"};
      8'h21: pair = {"c", "C"};
      8'h23: pair = {"d", "D"};
      8'h24: pair = {"e", "E"};
      8'h2B: pair = {"f", "F"};
      8'h34: pair = {"g", "G"};
      8'h33: pair = {"h", "H"};
      8'h43: pair = {"i", "I"};
      8'h3B: pair = {"j", "J"};
      8'h42: pair = {"k", "K"};
      8'h4B: pair = {"l", "L"};
      8'h3A: pair = {"m", "M"};
      8'h31: pair = {"n", "N"};
      8'h44: pair = {"o", "O"};
      8'h4D: pair = {"p", "P"};
      8'h15: pair = {"q", "Q"};
      8'h2D: pair = {"r", "R"};
      8'h1B: pair = {"s", "S"};
      8'h2C: pair = {"t", "T"};
      8'h3C: pair = {"u", "U"};
      8'h2A: pair = {"v", "V"};
      8'h1D: pair = {"w", "W"};
      8'h22: pair = {"x", "X"};
      8'h35: pair = {"y", "Y"};
      8'h1A: pair = {"z", "Z"};
      8'h16: pair = {"1", "!"};
      8'h1E: pair = {"2", "@"};
      8'h26: pair = {"3", "#"};
      8'h25: pair = {"4", "$"};
      8'h2E: pair = {"5", "%"};
      8'h36: pair = {"6", "^"};
      8'h3D: pair = {"7", "&"};
      8'h3E: pair = {"8", "*"};
      8'h46: pair = {"9", "("};
      8'h45: pair = {"0", ")"};
      8'h0E: pair = {8'h60, 8'h7E};
      8'h4E: pair = {"-", "_"};
      8'h55: pair = {"=", "+"};
      8'h5D: pair = {8'h5C, 8'h7C};
      8'h54: pair = {"[", "{"};
      8'h5B: pair = {"]", "}"};
      8'h4C: pair = {";", ":"};
      8'h52: pair = {8'h27, 8'h22};
      8'h41: pair = {",", "<"};
      8'h49: pair = {".", ">"};
      8'h4A: pair = {"/", "?"};
      8'h29: pair = {8'h20, 8'h20};
      8'h5A: pair = {8'h0D, 8'h0D};
      8'h66: pair = {8'h08, 8'h08};
      8'h0D: pair = {8'h09, 8'h09};
      8'h76: pair = {8'h1B, 8'h1B};
      default: pair = 16'h0000;
    endcase
  end

  assign unshifted_o = pair[15:8];
  assign shifted_o   = pair[7:0];

endmodule

// File: rtl/kbd_ascii_decoder.sv
// rtl/kbd_ascii_decoder.sv - modifier tracking, ASCII translation and character FIFO
module kbd_ascii_decoder
  import keyboard_common::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  kbd_event_t event_i,
  input  logic       valid_i,
  output logic [7:0] char_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [2:0] mods_o,
  output logic       overflow_o,
  input  logic       clear_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  kbd_event_t ev_q;
  logic       ev_valid_q;
  logic       lshift_q, rshift_q, lctrl_q, rctrl_q, caps_held_q, caps_lock_q;
  logic       lshift_d, rshift_d, lctrl_d, rctrl_d, caps_held_d, caps_lock_d;
  ascii_t     rom_unshifted, rom_shifted, mapped, char_d, char_q;
  logic       char_valid_d, char_valid_q;
  logic       shift_held, ctrl_held, is_mod;
  ascii_t     fifo_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic       empty, full, push, pop, drop, overflow_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ev_valid_q <= 1'b0;
      ev_q       <= '0;
    end else begin
      ev_valid_q <= valid_i;
      ev_q       <= event_i;
    end
  end

  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    caps_held_d = caps_held_q;
    caps_lock_d = caps_lock_q;
    if (ev_valid_q && !ev_q.is_extended) begin
      case (ev_q.keycode)
        SC_LSHIFT: lshift_d = !ev_q.is_break;
        SC_RSHIFT: rshift_d = !ev_q.is_break;
        SC_CTRL:   lctrl_d  = !ev_q.is_break;
        SC_CAPS: begin
          // typematic repeats arrive as makes with the held bit already set
          if (!ev_q.is_break && !caps_held_q) caps_lock_d = !caps_lock_q;
          caps_held_d = !ev_q.is_break;
        end
        default: ;
      endcase
    end
    if (ev_valid_q && ev_q.is_extended && (ev_q.keycode == SC_CTRL)) rctrl_d = !ev_q.is_break;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_held_q <= 1'b0;
      caps_lock_q <= 1'b0;
    end else begin
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      caps_held_q <= caps_held_d;
      caps_lock_q <= caps_lock_d;
    end
  end

  kbd_keymap_rom u_keymap (
    .keycode_i   (ev_q.keycode),
    .unshifted_o (rom_unshifted),
    .shifted_o   (rom_shifted)
  );

  assign shift_held = lshift_q | rshift_q;
  assign ctrl_held  = lctrl_q | rctrl_q;
  assign is_mod     = (ev_q.keycode == SC_LSHIFT) || (ev_q.keycode == SC_RSHIFT) ||
                      (ev_q.keycode == SC_CTRL)   || (ev_q.keycode == SC_CAPS);

  // lookup uses modifier registers before this event's own update lands
  always_comb begin
    mapped = 8'h00;
    if (ev_q.is_break) begin
      mapped = 8'h00;
    end else if (ev_q.is_extended) begin
      if (ev_q.keycode == SC_ENTER)         mapped = 8'h0D;
      else if (ev_q.keycode == SC_KP_SLASH) mapped = 8'h2F;
    end else if (!is_mod) begin
      if (is_letter(rom_unshifted)) mapped = (shift_held ^ caps_lock_q) ? rom_shifted : rom_unshifted;
      else                          mapped = shift_held ? rom_shifted : rom_unshifted;
    end
    char_d       = (ctrl_held && (mapped >= 8'h40) && (mapped <= 8'h7F)) ? (mapped & 8'h1F) : mapped;
    char_valid_d = ev_valid_q && (mapped != 8'h00);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      char_valid_q <= 1'b0;
      char_q       <= 8'h00;
    end else begin
      char_valid_q <= char_valid_d;
      char_q       <= char_d;
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && ready_i;
  assign push  = char_valid_q && (!full || pop);
  assign drop  = char_valid_q && full && !pop;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && !clear_i && push) fifo_q[wr_ptr_q[AW-1:0]] <= char_q;
  end

  assign valid_o    = !empty;
  assign char_o     = empty ? 8'h00 : fifo_q[rd_ptr_q[AW-1:0]];
  assign mods_o     = {caps_lock_q, ctrl_held, shift_held};
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_kbd_ascii_decoder.sv
// tb/tb_kbd_ascii_decoder.sv - directed vector bench for kbd_ascii_decoder
module tb_kbd_ascii_decoder;
  import keyboard_common::*;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  kbd_event_t event_i = '0;
  logic       valid_i = 1'b0;
  logic [7:0] char_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [2:0] mods_o;
  logic       overflow_o;
  logic       clear_i = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
    logic [7:0] exp_char;
    logic [2:0] exp_mods;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] hw_code [12] = '{8'h33, 8'h24, 8'h4B, 8'h4B, 8'h44, 8'h29, 8'h1D, 8'h44, 8'h2D, 8'h4B, 8'h23, 8'h5A};
  logic [7:0] hw_char [12] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D};

  kbd_ascii_decoder #(.FIFO_DEPTH(16)) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .event_i    (event_i),
    .valid_i    (valid_i),
    .char_o     (char_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .mods_o     (mods_o),
    .overflow_o (overflow_o),
    .clear_i    (clear_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic send(input logic brk, input logic ext, input logic [7:0] code);
    event_i = '{is_break: brk, is_extended: ext, keycode: code};
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic pop();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  initial begin
    vecs.push_back('{1'b0, 1'b0, 8'h12, 8'h00, 3'b001});
    vecs.push_back('{1'b0, 1'b0, 8'h1C, 8'h41, 3'b001});
    vecs.push_back('{1'b1, 1'b0, 8'h1C, 8'h00, 3'b001});
    vecs.push_back('{1'b1, 1'b0, 8'h12, 8'h00, 3'b000});
    vecs.push_back('{1'b0, 1'b0, 8'h1C, 8'h61, 3'b000});
    vecs.push_back('{1'b1, 1'b0, 8'h1C, 8'h00, 3'b000});
    vecs.push_back('{1'b0, 1'b0, 8'h58, 8'h00, 3'b100});
    vecs.push_back('{1'b0, 1'b0, 8'h58, 8'h00, 3'b100});
    vecs.push_back('{1'b0, 1'b0, 8'h58, 8'h00, 3'b100});
    vecs.push_back('{1'b1, 1'b0, 8'h58, 8'h00, 3'b100});
    vecs.push_back('{1'b0, 1'b0, 8'h1C, 8'h41, 3'b100});
    vecs.push_back('{1'b0, 1'b0, 8'h12, 8'h00, 3'b101});
    vecs.push_back('{1'b0, 1'b0, 8'h1C, 8'h61, 3'b101});
    vecs.push_back('{1'b0, 1'b0, 8'h16, 8'h21, 3'b101});
    vecs.push_back('{1'b1, 1'b0, 8'h12, 8'h00, 3'b100});
    vecs.push_back('{1'b0, 1'b0, 8'h16, 8'h31, 3'b100});
    vecs.push_back('{1'b0, 1'b0, 8'h58, 8'h00, 3'b000});
    vecs.push_back('{1'b1, 1'b0, 8'h58, 8'h00, 3'b000});
    vecs.push_back('{1'b0, 1'b1, 8'h14, 8'h00, 3'b010});
    vecs.push_back('{1'b0, 1'b0, 8'h21, 8'h03, 3'b010});
    vecs.push_back('{1'b1, 1'b0, 8'h21, 8'h00, 3'b010});
    vecs.push_back('{1'b1, 1'b1, 8'h14, 8'h00, 3'b000});
    vecs.push_back('{1'b0, 1'b1, 8'h5A, 8'h0D, 3'b000});
    vecs.push_back('{1'b0, 1'b1, 8'h75, 8'h00, 3'b000});
    vecs.push_back('{1'b0, 1'b1, 8'h4A, 8'h2F, 3'b000});
    vecs.push_back('{1'b0, 1'b0, 8'h4A, 8'h2F, 3'b000});
    vecs.push_back('{1'b0, 1'b0, 8'h59, 8'h00, 3'b001});
    vecs.push_back('{1'b0, 1'b0, 8'h4A, 8'h3F, 3'b001});
    vecs.push_back('{1'b0, 1'b1, 8'h4A, 8'h2F, 3'b001});
    vecs.push_back('{1'b0, 1'b0, 8'h2B, 8'h46, 3'b001});
    vecs.push_back('{1'b1, 1'b0, 8'h59, 8'h00, 3'b000});
    vecs.push_back('{1'b0, 1'b0, 8'h14, 8'h00, 3'b010});
    vecs.push_back('{1'b0, 1'b0, 8'h1C, 8'h01, 3'b010});
    vecs.push_back('{1'b0, 1'b0, 8'h29, 8'h20, 3'b010});
    vecs.push_back('{1'b1, 1'b0, 8'h14, 8'h00, 3'b000});
    vecs.push_back('{1'b0, 1'b0, 8'h66, 8'h08, 3'b000});
    vecs.push_back('{1'b0, 1'b0, 8'h0D, 8'h09, 3'b000});
    vecs.push_back('{1'b0, 1'b0, 8'h76, 8'h1B, 3'b000});
    vecs.push_back('{1'b0, 1'b0, 8'h07, 8'h00, 3'b000});
    vecs.push_back('{1'b0, 1'b1, 8'h12, 8'h00, 3'b000});
    vecs.push_back('{1'b0, 1'b0, 8'h1C, 8'h61, 3'b000});

    tick();
    tick();
    chk("reset valid_o", 8'(valid_o), 8'h00);
    chk("reset char_o", char_o, 8'h00);
    chk("reset mods_o", 8'(mods_o), 8'h00);
    chk("reset overflow_o", 8'(overflow_o), 8'h00);
    reset_n_i = 1'b1;
    tick();

    foreach (vecs[i]) begin
      send(vecs[i].brk, vecs[i].ext, vecs[i].code);
      tick();
      tick();
      chk($sformatf("vec%0d mods", i), 8'(mods_o), 8'(vecs[i].exp_mods));
      if (vecs[i].exp_char != 8'h00) begin
        chk($sformatf("vec%0d valid", i), 8'(valid_o), 8'h01);
        chk($sformatf("vec%0d char", i), char_o, vecs[i].exp_char);
        pop();
      end
      chk($sformatf("vec%0d empty", i), 8'(valid_o), 8'h00);
    end

    for (int i = 0; i < 12; i++) begin
      send(1'b0, 1'b0, hw_code[i]);
      chk($sformatf("hw%0d lat N", i), 8'(valid_o), 8'h00);
      tick();
      chk($sformatf("hw%0d lat N+1", i), 8'(valid_o), 8'h00);
      tick();
      chk($sformatf("hw%0d lat N+2", i), 8'(valid_o), 8'h01);
      chk($sformatf("hw%0d char", i), char_o, hw_char[i]);
      pop();
      send(1'b1, 1'b0, hw_code[i]);
      tick();
      tick();
      chk($sformatf("hw%0d brk", i), 8'(valid_o), 8'h00);
    end

    send(1'b0, 1'b0, 8'h12);
    send(1'b0, 1'b0, 8'h33);
    send(1'b0, 1'b0, 8'h24);
    send(1'b1, 1'b0, 8'h12);
    send(1'b0, 1'b0, 8'h24);
    tick();
    tick();
    chk("b2b char0", char_o, 8'h48);
    pop();
    chk("b2b char1", char_o, 8'h45);
    pop();
    chk("b2b char2", char_o, 8'h65);
    pop();
    chk("b2b empty", 8'(valid_o), 8'h00);
    chk("b2b mods", 8'(mods_o), 8'h00);

    for (int i = 0; i < 16; i++) send(1'b0, 1'b0, 8'h1C);
    tick();
    tick();
    chk("fill16 overflow", 8'(overflow_o), 8'h00);
    send(1'b0, 1'b0, 8'h1C);
    send(1'b0, 1'b0, 8'h1C);
    tick();
    tick();
    chk("fill18 overflow", 8'(overflow_o), 8'h01);
    chk("fill18 valid", 8'(valid_o), 8'h01);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clear valid", 8'(valid_o), 8'h00);
    chk("clear overflow", 8'(overflow_o), 8'h00);
    chk("clear char", char_o, 8'h00);

    for (int i = 0; i < 16; i++) send(1'b0, 1'b0, 8'h1C);
    tick();
    tick();
    send(1'b0, 1'b0, 8'h32);
    tick();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("full pop+push overflow", 8'(overflow_o), 8'h00);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d valid", i), 8'(valid_o), 8'h01);
      chk($sformatf("drain%0d char", i), char_o, (i == 15) ? 8'h62 : 8'h61);
      pop();
    end
    chk("drain empty", 8'(valid_o), 8'h00);

    send(1'b0, 1'b0, 8'h12);
    send(1'b0, 1'b0, 8'h1C);
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tick();
    tick();
    chk("clear inflight valid", 8'(valid_o), 8'h00);
    chk("clear keeps mods", 8'(mods_o), 8'h01);

    send(1'b0, 1'b0, 8'h1C);
    tick();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    chk("midreset valid", 8'(valid_o), 8'h00);
    chk("midreset mods", 8'(mods_o), 8'h00);
    chk("midreset char", char_o, 8'h00);
    tick();
    tick();
    chk("midreset lost", 8'(valid_o), 8'h00);
    send(1'b0, 1'b0, 8'h1C);
    tick();
    tick();
    chk("postreset valid", 8'(valid_o), 8'h01);
    chk("postreset char", char_o, 8'h61);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
